// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream multiplexer with a single output register.
// A round-robin or fixed-priority arbiter picks one source per transfer.
module mux_rr_stream #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [N_CH-1:0]         i_valid,
    input  logic [N_CH*WIDTH-1:0]   i_data,
    output logic [N_CH-1:0]         o_ready,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output logic [SEL_W-1:0]        o_sel,
    input  logic                    i_ready
);

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;

    logic               w_load_en;
    logic [SEL_W-1:0]   w_base;
    logic               w_found;
    logic [SEL_W-1:0]   w_gnt;
    logic [WIDTH-1:0]   w_word;
    logic [SEL_W-1:0]   w_next_ptr;
    logic               w_xfer;

    assign w_load_en = ~r_valid | i_ready;
    assign w_base    = (MODE == 0) ? r_ptr : '0;

    // Scan starts at the pointer and wraps; fixed priority scans from 0.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_word  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            int unsigned      idx;
            logic [SEL_W-1:0] idx_s;
            idx   = (32'(w_base) + i) % N_CH;
            idx_s = SEL_W'(idx);
            if (!w_found && i_valid[idx_s]) begin
                w_found = 1'b1;
                w_gnt   = idx_s;
                w_word  = WIDTH'(i_data >> (idx * WIDTH));
            end
        end
    end

    assign w_xfer     = w_found & w_load_en;
    assign w_next_ptr = (w_gnt == SEL_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        o_ready = '0;
        if (w_xfer) begin
            o_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_sel   <= w_gnt;
            if (MODE == 0) begin
                r_ptr <= w_next_ptr;
            end
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- N-channel, WIDTH-bit streaming multiplexer.
- Generalises the 2:1 single-bit mux to N sources, each with a valid/ready handshake.
- An arbiter picks one source per transfer, in round-robin or fixed-priority mode. The winning word is captured in a single output register stage.
- Sits between multiple producers (e.g. per-channel datapaths) and one shared downstream consumer.

Parameters:
- N_CH, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data width per channel in bits; must be at least 1.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_W, $clog2(N_CH), localparam, width of the channel index.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  N_CH  per-channel valid; bit k belongs to channel k.
- i_data  input  N_CH*WIDTH  packed data; channel k occupies bits [k*WIDTH +: WIDTH].
- o_ready  output  N_CH  per-channel ready; one-hot or all zero.
- o_valid  output  1  output register holds a word.
- o_data  output  WIDTH  registered selected word.
- o_sel  output  SEL_W  index of the channel that supplied o_data.
- i_ready  input  1  downstream ready.

Behaviour:
- Reset (i_rstn=0, asynchronous):
  - o_valid=0, o_data=0, o_sel=0.
  - Round-robin pointer ptr=0.
  - Any held word is discarded; no transfer is reported after reset.
- Transfer definitions:
  - Input transfer on channel k: i_valid[k] & o_ready[k] at a rising edge.
  - Output transfer: o_valid & i_ready at a rising edge.
- Load enable: load_en = ~o_valid | i_ready. The register accepts a new word when empty, or in the same cycle the held word is taken (full throughput, 1 word per cycle).
- Grant (combinational, computed every cycle):
  - MODE=0: first set bit of i_valid, searching from ptr upward and wrapping N_CH-1 to 0.
  - MODE=1: lowest set index of i_valid; ptr is unused.
  - o_ready[g] = load_en & i_valid[g] for the granted g. All other o_ready bits are 0.
  - o_ready must not depend on i_valid of other channels beyond the arbitration itself.
  - o_ready has a combinational path from i_ready; this path is intentional.
- On an input transfer from channel g:
  - o_data <= i_data[g].
  - o_sel <= g.
  - o_valid <= 1.
  - MODE=0 only: ptr <= (g+1) mod N_CH.
- Output transfer with no input transfer in the same cycle: o_valid <= 0; o_data and o_sel hold their last values.
- Stall (o_valid & ~i_ready): o_data, o_sel, o_valid and ptr all hold; every o_ready bit is 0.
- Latency: one cycle from input transfer to o_valid; a word is presented on the next cycle.
- No input valid while load_en=1: no grant, ptr unchanged, o_valid falls after an output transfer.
- Source protocol: a source holds i_data stable while valid and not ready. This is required of sources, not checked by the block.
- Fairness (MODE=0): with all channels continuously valid and i_ready=1, grants rotate 0,1,2,...,N_CH-1,0,...
  - No channel waits more than N_CH-1 grants once valid.
- Simultaneous output and input transfer in one cycle: the new word replaces the old one and o_valid stays 1.

Test Plan:
1. Reset mid-stream: N_CH=4, WIDTH=8, MODE=0. Hold i_valid=4'b1111, i_ready=1, assert i_rstn=0 asynchronously mid-cycle.
   - Required: o_valid=0, o_data=0, o_sel=0 immediately.
   - After release: first grant is channel 0.
2. Round-robin rotation: i_valid=4'b1111, data k=8'hA0+k, i_ready=1.
   - Required o_sel sequence: 0,1,2,3,0,1 on consecutive cycles, with o_data 8'hA0,A1,A2,A3,A0,A1.
   - o_ready is one-hot each cycle.
3. Sparse requests and pointer wrap: after a grant to channel 3, drive i_valid=4'b0101.
   - Required: next grant channel 0, then channel 2 (ptr wraps 3 to 0).
4. Back-pressure: o_valid=1, o_data=8'h55, then drop i_ready for 3 cycles while i_valid=4'b1111.
   - Required: o_data=8'h55 and o_sel stable, o_ready=0.
   - On i_ready=1: word consumed and the next grant loaded in the same edge, o_valid stays 1.
5. Fixed priority (MODE=1): i_valid=4'b1010 continuously, i_ready=1.
   - Required: channel 1 granted every cycle; channel 3 never granted while bit 1 is set.
   - On i_valid=4'b1000: channel 3 granted.
6. Drain and idle: single word on channel 2 (8'h3C), then i_valid=0, i_ready=1.
   - Required: o_valid=1 for exactly one cycle with o_sel=2 and o_data=8'h3C.
   - Afterwards o_valid=0, o_data holds 8'h3C, ptr=3.
